// File: rtl/vector_memory.sv
// Vector data memory: serves one strided, masked vector load or store per request
// as LANES single-word beats over a single-port word array, then pulses resp_valid.
module vector_memory #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 512,
    parameter int LANES  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [AW-1:0]             req_addr,
    input  logic [AW-1:0]             req_stride,
    input  logic [LANES-1:0]          req_mask,
    input  logic [LANES*WORD_W-1:0]   req_wdata,
    output logic                      resp_valid,
    output logic [LANES*WORD_W-1:0]   resp_rdata,
    output logic                      busy
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_STORE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [WORD_W-1:0]       mem [DEPTH];
    logic [1:0]              state;
    logic [LW-1:0]           lane_cnt;
    logic [AW-1:0]           ptr;
    logic [AW-1:0]           stride_q;
    logic [LANES-1:0]        mask_q;
    logic [LANES*WORD_W-1:0] wdata_q;
    logic [LANES*WORD_W-1:0] lane_buf;
    logic [LANES*WORD_W-1:0] next_buf;
    logic [WORD_W-1:0]       wdata_lane;
    logic                    last_beat;
    int                      lane_base;

    assign req_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign last_beat  = (lane_cnt == LAST_LANE);

    // next_buf is the lane buffer with the current beat merged in, so the final
    // beat can be published to resp_rdata on the same edge it is read.
    always_comb begin
        lane_base  = int'(lane_cnt) * WORD_W;
        next_buf   = lane_buf;
        next_buf[lane_base +: WORD_W] = mask_q[lane_cnt] ? mem[ptr] : '0;
        wdata_lane = wdata_q[lane_base +: WORD_W];
    end

    always_ff @(posedge clk) begin
        if (reset && state == S_STORE && mask_q[lane_cnt])
            mem[ptr] <= wdata_lane;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            lane_cnt   <= '0;
            ptr        <= '0;
            stride_q   <= '0;
            mask_q     <= '0;
            wdata_q    <= '0;
            lane_buf   <= '0;
            resp_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        stride_q <= req_stride;
                        mask_q   <= req_mask;
                        wdata_q  <= req_wdata;
                        ptr      <= req_addr;
                        lane_cnt <= '0;
                        state    <= req_write ? S_STORE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    lane_buf <= next_buf;
                    ptr      <= ptr + stride_q;
                    lane_cnt <= lane_cnt + LW'(1);
                    if (last_beat) begin
                        resp_rdata <= next_buf;
                        state      <= S_RESP;
                    end
                end
                S_STORE: begin
                    ptr      <= ptr + stride_q;
                    lane_cnt <= lane_cnt + LW'(1);
                    if (last_beat)
                        state <= S_RESP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
